cbx_param_dbuf: RTL and testbench
=================================

Name: cbx_param_dbuf

Overview:
- Parametrised X-direction connection block: generalises the fixed 9-track, fixed-mux-size connection blocks to CHAN_W tracks, NUM_IPIN grid pins and MUX_SIZE-input muxes.
- Adds a double-buffered configuration chain. A shadow shift register loads through ccff_head/ccff_tail, and an explicit commit copies it into the active select register. The routing therefore does not glitch while a new configuration is shifted in.
- A bit counter and FSM validate that exactly the full frame has been shifted before a commit is accepted.
- Instantiated per tile column in the routing fabric; it chains ccff_tail to the next block's ccff_head.

Parameters:
- CHAN_W, 9, tracks per direction.
- NUM_IPIN, 8, pins driven from the channel.
- MUX_SIZE, 6, inputs per pin mux (even, 2..2*CHAN_W).
- STRIDE, 4, track step between successive left/right input pairs.
- SEL_W, clog2(MUX_SIZE), select bits per pin (derived).
- TOTAL, NUM_IPIN*SEL_W, configuration frame length in bits (derived).

Ports:
- prog_clk  in  1  configuration/sequential clock.
- prog_reset_n  in  1  asynchronous active-low reset.
- chanx_left_in  in  CHAN_W  tracks entering from the left.
- chanx_right_in  in  CHAN_W  tracks entering from the right.
- chanx_left_out  out  CHAN_W  equals chanx_right_in (combinational pass-through).
- chanx_right_out  out  CHAN_W  equals chanx_left_in (combinational pass-through).
- ipin_out  out  NUM_IPIN  mux outputs to the grid pins.
- ccff_head  in  1  serial configuration input.
- cfg_en  in  1  shift enable.
- cfg_commit  in  1  single-cycle commit request.
- cfg_clear  in  1  single-cycle abort; resets the counter and error flag.
- ccff_tail  out  1  serial configuration output.
- cfg_valid  out  1  high once any commit has succeeded.
- cfg_loaded  out  1  one-cycle pulse on a successful commit.
- cfg_err  out  1  sticky commit error.

Behaviour:
- Reset (prog_reset_n=0, asynchronous): shadow=0, active=0, count=0, state=IDLE, cfg_valid=0, cfg_loaded=0, cfg_err=0. ccff_tail=0 because it equals shadow[TOTAL-1].
- Shift: when cfg_en=1 at a prog_clk rising edge, shadow <= {shadow[TOTAL-2:0], ccff_head}. count increments and saturates at TOTAL+1.
- ccff_tail is shadow[TOTAL-1]: registered, with a latency of TOTAL cycles from head to tail.
- FSM, derived from count:
  - IDLE: count=0.
  - SHIFT: 0<count<TOTAL.
  - FULL: count=TOTAL.
  - OVER: count>TOTAL.
  - Shifting keeps the shadow register updating in every state.
- Commit (cfg_commit=1, cfg_en=0, state=FULL):
  - active <= shadow; cfg_valid <= 1; cfg_loaded pulses high for the next cycle.
  - count <= 0, state <= IDLE. The shadow register is retained.
- cfg_commit in IDLE, SHIFT or OVER, or asserted together with cfg_en:
  - No commit takes place and active is unchanged.
  - cfg_err <= 1 and stays set until cfg_clear or reset.
  - Any shift requested in the same cycle still occurs.
- cfg_clear: count <= 0, state <= IDLE, cfg_err <= 0. Shadow and active are unchanged.
  - cfg_clear has priority over cfg_commit in the same cycle.
  - cfg_clear together with cfg_en: the shift occurs and count becomes 0, not 1.
- Select decode: sel_k = active[k*SEL_W +: SEL_W]. The first bit shifted in lands in the MSB of pin NUM_IPIN-1.
- Mux input j of pin k:
  - Track t = (k + (j>>1)*STRIDE) mod CHAN_W.
  - j even selects chanx_left_in[t]; j odd selects chanx_right_in[t].
- ipin_out[k] = (cfg_valid && sel_k < MUX_SIZE) ? in_k[sel_k] : 0.
  - An out-of-range select value drives 0.
  - Before the first commit all pins drive 0.
- ipin_out is combinational from the active register and the channel inputs. It changes only on the commit edge or when the channel changes, never during shifting.
- Pass-throughs are purely combinational and independent of reset.

Decomposition:
- Shared package (cb_pkg):
  - state enum {IDLE, SHIFT, FULL, OVER}.
  - clog2-based SEL_W/TOTAL helper functions.
  - Track-index function track_of(k, j, CHAN_W, STRIDE).
- Sub-module cb_cfg_dbuf: owns the shadow register, the active register, the counter, the FSM and the flags, and exports the active vector.
- The top level holds the generate loop of NUM_IPIN muxes and the pass-throughs.

Test Plan (defaults: TOTAL=24, SEL_W=3):
- Reset, then drive chanx_left_in=9'h1FF -> ipin_out=0 (cfg_valid=0), chanx_right_out=9'h1FF, ccff_tail=0.
- Shift 24 bits loading sel_0=5, all others 0, then commit:
  - cfg_loaded pulses for one cycle, cfg_valid=1, cfg_err=0.
  - Setting chanx_right_in[8]=1 gives ipin_out[0]=1, since pin 0 input 5 is right track 8.
- Shift 23 bits then commit -> cfg_err=1, active unchanged, ipin_out unchanged. Then cfg_clear -> cfg_err=0, count=0.
- Shift 25 bits then commit -> cfg_err=1 (OVER). Shift a 1 then 24 zeros -> ccff_tail observes the 1 exactly 24 cycles after it entered.
- Load sel_3=7 (out of range) -> after commit ipin_out[3]=0 for every channel value.
- After a valid commit, shift a new frame while toggling channel inputs -> ipin_out follows only the old selects until the second commit. Assert prog_reset_n mid-shift -> all flags and ipin_out drop to 0 immediately.

Source files
------------

// File: rtl/cb_pkg.sv
// Shared types and elaboration-time helpers for the parametrised X connection block.
package cb_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL, OVER} cfg_state_e;

  function automatic int sel_w_of(input int mux_size);
    return (mux_size < 2) ? 1 : $clog2(mux_size);
  endfunction

  function automatic int total_of(input int num_ipin, input int mux_size);
    return num_ipin * sel_w_of(mux_size);
  endfunction

  // Input pairs (left, right) walk across the channel STRIDE tracks at a time.
  function automatic int track_of(input int k, input int j, input int chan_w, input int stride);
    return (k + (j / 2) * stride) % chan_w;
  endfunction

endpackage

// File: rtl/cb_cfg_dbuf.sv
// Double-buffered configuration chain: shadow shift register, frame counter/FSM,
// and the active select register that only changes on a validated commit.
module cb_cfg_dbuf
  import cb_pkg::*;
#(
  parameter int TOTAL = 24
) (
  input  logic             prog_clk,
  input  logic             prog_reset_n,
  input  logic             ccff_head,
  input  logic             cfg_en,
  input  logic             cfg_commit,
  input  logic             cfg_clear,
  output logic             ccff_tail,
  output logic             cfg_valid,
  output logic             cfg_loaded,
  output logic             cfg_err,
  output logic [TOTAL-1:0] active
);

  localparam int CNT_W = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] OVER_CNT = CNT_W'(TOTAL + 1);

  logic [TOTAL-1:0] shadow_q, shadow_d;
  logic [TOTAL-1:0] active_q, active_d;
  logic [CNT_W-1:0] count_q, count_d;
  cfg_state_e       state_q, state_d;
  logic             valid_q, valid_d;
  logic             loaded_q, loaded_d;
  logic             err_q, err_d;
  logic             commit_ok;

  assign commit_ok = cfg_commit && !cfg_en && !cfg_clear && (state_q == FULL);

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    count_d  = count_q;
    valid_d  = valid_q;
    loaded_d = 1'b0;
    err_d    = err_q;

    if (cfg_en) begin
      shadow_d = {shadow_q[TOTAL-2:0], ccff_head};
      if (count_q != OVER_CNT) count_d = count_q + 1'b1;
    end

    // Clear wins over commit; a shift in the same cycle still lands but the count restarts.
    if (cfg_clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if (cfg_commit) begin
      if (commit_ok) begin
        active_d = shadow_q;
        valid_d  = 1'b1;
        loaded_d = 1'b1;
        count_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (count_d == '0)           state_d = IDLE;
    else if (count_d < FULL_CNT) state_d = SHIFT;
    else if (count_d == FULL_CNT) state_d = FULL;
    else                         state_d = OVER;
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      shadow_q <= '0;
      active_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      count_q  <= count_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail  = shadow_q[TOTAL-1];
  assign cfg_valid  = valid_q;
  assign cfg_loaded = loaded_q;
  assign cfg_err    = err_q;
  assign active     = active_q;

endmodule

// File: rtl/cbx_param_dbuf.sv
// Parametrised X-direction connection block: per-pin muxes over the channel
// driven by a double-buffered configuration, plus channel pass-throughs.
module cbx_param_dbuf
  import cb_pkg::*;
#(
  parameter int CHAN_W   = 9,
  parameter int NUM_IPIN = 8,
  parameter int MUX_SIZE = 6,
  parameter int STRIDE   = 4
) (
  input  logic                prog_clk,
  input  logic                prog_reset_n,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  input  logic                ccff_head,
  input  logic                cfg_en,
  input  logic                cfg_commit,
  input  logic                cfg_clear,
  output logic                ccff_tail,
  output logic                cfg_valid,
  output logic                cfg_loaded,
  output logic                cfg_err
);

  localparam int SEL_W = sel_w_of(MUX_SIZE);
  localparam int TOTAL = total_of(NUM_IPIN, MUX_SIZE);
  localparam int PAD_W = 1 << SEL_W;

  logic [TOTAL-1:0] active;

  cb_cfg_dbuf #(.TOTAL(TOTAL)) u_cfg (
    .prog_clk     (prog_clk),
    .prog_reset_n (prog_reset_n),
    .ccff_head    (ccff_head),
    .cfg_en       (cfg_en),
    .cfg_commit   (cfg_commit),
    .cfg_clear    (cfg_clear),
    .ccff_tail    (ccff_tail),
    .cfg_valid    (cfg_valid),
    .cfg_loaded   (cfg_loaded),
    .cfg_err      (cfg_err),
    .active       (active)
  );

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  // Mux inputs are padded to a power of two with zeros so out-of-range selects drive 0.
  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
    logic [PAD_W-1:0] in_pad;
    logic [SEL_W-1:0] sel;

    assign sel = active[k*SEL_W +: SEL_W];

    for (genvar j = 0; j < PAD_W; j++) begin : g_in
      if (j >= MUX_SIZE) begin : g_pad
        assign in_pad[j] = 1'b0;
      end else if (j % 2 == 0) begin : g_left
        assign in_pad[j] = chanx_left_in[track_of(k, j, CHAN_W, STRIDE)];
      end else begin : g_right
        assign in_pad[j] = chanx_right_in[track_of(k, j, CHAN_W, STRIDE)];
      end
    end

    assign ipin_out[k] = cfg_valid & in_pad[sel];
  end

endmodule

// File: tb/tb_cbx_param_dbuf.sv
// Directed bench for cbx_param_dbuf at default parameters (9 tracks, 8 pins, 6-input muxes).
module tb_cbx_param_dbuf;

  logic       prog_clk = 1'b0;
  logic       prog_reset_n = 1'b1;
  logic [8:0] chanx_left_in = '0;
  logic [8:0] chanx_right_in = '0;
  logic [8:0] chanx_left_out;
  logic [8:0] chanx_right_out;
  logic [7:0] ipin_out;
  logic       ccff_head = 1'b0;
  logic       cfg_en = 1'b0;
  logic       cfg_commit = 1'b0;
  logic       cfg_clear = 1'b0;
  logic       ccff_tail;
  logic       cfg_valid;
  logic       cfg_loaded;
  logic       cfg_err;

  int n_cmp = 0;
  int n_bad = 0;

  cbx_param_dbuf dut (
    .prog_clk        (prog_clk),
    .prog_reset_n    (prog_reset_n),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ipin_out        (ipin_out),
    .ccff_head       (ccff_head),
    .cfg_en          (cfg_en),
    .cfg_commit      (cfg_commit),
    .cfg_clear       (cfg_clear),
    .ccff_tail       (ccff_tail),
    .cfg_valid       (cfg_valid),
    .cfg_loaded      (cfg_loaded),
    .cfg_err         (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Shifts v MSB first; leaves cfg_en low afterwards.
  task automatic shift_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en    = 1'b1;
      ccff_head = v[i];
      tick();
    end
    cfg_en    = 1'b0;
    ccff_head = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic clear();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  // Pin 0 sel=5 -> right track 8; pin 3 sel=7 -> 0; other pins sel=0 -> left track k.
  function automatic logic [7:0] exp_old(input logic [8:0] l, input logic [8:0] r);
    logic [7:0] e;
    e    = l[7:0];
    e[0] = r[8];
    e[3] = 1'b0;
    return e;
  endfunction

  initial begin
    // Reset state and pass-throughs
    #2 prog_reset_n = 1'b0;
    chanx_left_in = 9'h1FF;
    #1;
    check("rst_ipin", 32'(ipin_out), 32'h0);
    check("rst_right_out", 32'(chanx_right_out), 32'h1FF);
    check("rst_tail", 32'(ccff_tail), 32'h0);
    check("rst_valid", 32'(cfg_valid), 32'h0);
    check("rst_err", 32'(cfg_err), 32'h0);
    chanx_right_in = 9'h0A5;
    #1;
    check("left_out_pass", 32'(chanx_left_out), 32'h0A5);
    chanx_right_in = 9'h000;
    tick();
    prog_reset_n = 1'b1;
    tick();
    check("idle_ipin", 32'(ipin_out), 32'h0);

    // Full frame sel_0=5, then commit
    shift_bits(32'h000005, 24);
    check("frame_tail", 32'(ccff_tail), 32'h0);
    check("pre_commit_ipin", 32'(ipin_out), 32'h0);
    commit();
    check("commit_loaded", 32'(cfg_loaded), 32'h1);
    check("commit_valid", 32'(cfg_valid), 32'h1);
    check("commit_err", 32'(cfg_err), 32'h0);
    tick();
    check("loaded_pulse_end", 32'(cfg_loaded), 32'h0);
    check("sel5_left_ones", 32'(ipin_out), 32'hFE);
    chanx_right_in = 9'h100;
    #1;
    check("sel5_right8", 32'(ipin_out), 32'hFF);
    chanx_left_in = 9'h000;
    #1;
    check("sel5_only_right8", 32'(ipin_out), 32'h01);

    // Short frame: commit rejected, active kept
    shift_bits(32'h7FFFFF, 23);
    commit();
    check("short_err", 32'(cfg_err), 32'h1);
    check("short_loaded", 32'(cfg_loaded), 32'h0);
    check("short_ipin_kept", 32'(ipin_out), 32'h01);
    clear();
    check("clear_err", 32'(cfg_err), 32'h0);
    shift_bits(32'h000005, 24);
    commit();
    check("after_clear_loaded", 32'(cfg_loaded), 32'h1);
    check("after_clear_err", 32'(cfg_err), 32'h0);

    // Over-long frame, then head-to-tail latency
    shift_bits(32'h0, 25);
    commit();
    check("over_err", 32'(cfg_err), 32'h1);
    check("over_loaded", 32'(cfg_loaded), 32'h0);
    clear();
    shift_bits(32'h1, 1);
    check("lat_tail_entry", 32'(ccff_tail), 32'h0);
    for (int i = 1; i <= 24; i++) begin
      shift_bits(32'h0, 1);
      check($sformatf("lat_tail_%0d", i + 1), 32'(ccff_tail), (i == 23) ? 32'h1 : 32'h0);
    end
    clear();

    // Out-of-range select on pin 3
    shift_bits(32'h000E05, 24);
    commit();
    check("oor_loaded", 32'(cfg_loaded), 32'h1);
    chanx_left_in  = 9'h1FF;
    chanx_right_in = 9'h1FF;
    #1;
    check("oor_all_ones", 32'(ipin_out), 32'hF7);
    for (int i = 0; i < 4; i++) begin
      chanx_left_in  = 9'($urandom);
      chanx_right_in = 9'($urandom);
      #1;
      check($sformatf("oor_pin3_%0d", i), 32'(ipin_out[3]), 32'h0);
    end

    // New frame shifted while channel toggles: outputs follow old selects only
    for (int i = 0; i < 24; i++) begin
      chanx_left_in  = 9'($urandom);
      chanx_right_in = 9'($urandom);
      cfg_en    = 1'b1;
      ccff_head = 1'b0;
      #1;
      if (i % 4 == 0)
        check($sformatf("shadow_hold_%0d", i), 32'(ipin_out), 32'(exp_old(chanx_left_in, chanx_right_in)));
      tick();
    end
    cfg_en = 1'b0;
    check("pre_second_commit", 32'(ipin_out), 32'(exp_old(chanx_left_in, chanx_right_in)));
    commit();
    chanx_left_in  = 9'h0AA;
    chanx_right_in = 9'h1FF;
    #1;
    check("second_commit_sel0", 32'(ipin_out), 32'hAA);

    // Commit with shift is an error; then async reset mid-shift
    shift_bits(32'h3, 2);
    cfg_en     = 1'b1;
    ccff_head  = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("commit_with_en_err", 32'(cfg_err), 32'h1);
    check("commit_with_en_ipin", 32'(ipin_out), 32'hAA);
    #3 prog_reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(cfg_valid), 32'h0);
    check("async_rst_err", 32'(cfg_err), 32'h0);
    check("async_rst_loaded", 32'(cfg_loaded), 32'h0);
    check("async_rst_ipin", 32'(ipin_out), 32'h0);
    check("async_rst_tail", 32'(ccff_tail), 32'h0);
    cfg_en = 1'b0;
    tick();
    prog_reset_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
